// File: rtl/lcd_timing_driver.sv
// lcd_timing_driver
//
// Source end of the RGB-LCD pixel interface. Two free-running counters walk
// the raster (h_cnt per pixel clock, v_cnt per line). Panel timing
// (HS/VS/DE) is decoded from them. The pixel colour mux is asked for
// column/row one cycle before DE so that its registered colour lands on
// lcd_rgb in the same cycle DE shows that pixel. A one-cycle frame_tick
// marks the end of the last active line for game logic.
//
// Ports:
//   lcd_pclk    in   1   pixel clock
//   rst_n       in   1   asynchronous, active-low reset
//   lcd_en      in   1   1 = run raster, 0 = hold idle
//   pixel_data  in   24  colour from pixel mux (1-cycle latency after xpos/ypos)
//   pixel_xpos  out  11  requested column, 0 outside the request window
//   pixel_ypos  out  11  requested row, 0 outside the request window
//   h_disp      out  11  constant active width
//   v_disp      out  11  constant active height
//   lcd_hs      out  1   horizontal sync, active low
//   lcd_vs      out  1   vertical sync, active low
//   lcd_de      out  1   data enable, active high
//   lcd_rgb     out  24  pixel bus to panel
//   lcd_bl      out  1   backlight enable (lcd_en delayed one clock)
//   frame_tick  out  1   one-cycle pulse after the last active line
module lcd_timing_driver #(
    parameter int H_SYNC  = 41,
    parameter int H_BACK  = 2,
    parameter int H_DISP  = 480,
    parameter int H_FRONT = 2,
    parameter int V_SYNC  = 10,
    parameter int V_BACK  = 2,
    parameter int V_DISP  = 272,
    parameter int V_FRONT = 2
) (
    input  logic        lcd_pclk,
    input  logic        rst_n,
    input  logic        lcd_en,
    input  logic [23:0] pixel_data,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic [10:0] h_disp,
    output logic [10:0] v_disp,
    output logic        lcd_hs,
    output logic        lcd_vs,
    output logic        lcd_de,
    output logic [23:0] lcd_rgb,
    output logic        lcd_bl,
    output logic        frame_tick
);

    localparam logic [10:0] H_LAST      = 11'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
    localparam logic [10:0] H_SYNC_END  = 11'(H_SYNC);
    localparam logic [10:0] H_START     = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_END       = 11'(H_SYNC + H_BACK + H_DISP);
    localparam logic [10:0] H_REQ_START = 11'(H_SYNC + H_BACK - 1);
    localparam logic [10:0] H_REQ_END   = 11'(H_SYNC + H_BACK + H_DISP - 1);

    localparam logic [10:0] V_LAST      = 11'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
    localparam logic [10:0] V_SYNC_END  = 11'(V_SYNC);
    localparam logic [10:0] V_START     = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] V_END       = 11'(V_SYNC + V_BACK + V_DISP);
    localparam logic [10:0] V_ACT_LAST  = 11'(V_SYNC + V_BACK + V_DISP - 1);

    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic        running;
    logic        v_act;
    logic        h_act;
    logic        h_req;
    logic        data_req;

    // running is lcd_en delayed by one clock. The counters only advance once
    // running is set, so the first enabled cycle presents position (0,0) and
    // the next edge moves on to (1,0). Dropping lcd_en clears the counters
    // and running on the same edge, so the following cycle is fully idle.
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt      <= '0;
            v_cnt      <= '0;
            running    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            running    <= lcd_en;
            frame_tick <= lcd_en && running && (h_cnt == H_LAST) && (v_cnt == V_ACT_LAST);
            if (!lcd_en) begin
                h_cnt <= '0;
                v_cnt <= '0;
            end else if (running) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 11'd1;
                end else begin
                    h_cnt <= h_cnt + 11'd1;
                end
            end
        end
    end

    // Everything panel-facing is gated by running, so reset and the idle
    // state show hs=vs=1, de=0, rgb=0 even though the counters sit at (0,0).
    // The request window leads DE by one column to cover the mux's register.
    always_comb begin
        v_act      = (v_cnt >= V_START) && (v_cnt < V_END);
        h_act      = (h_cnt >= H_START) && (h_cnt < H_END);
        h_req      = (h_cnt >= H_REQ_START) && (h_cnt < H_REQ_END);
        data_req   = running && v_act && h_req;
        lcd_hs     = !(running && (h_cnt < H_SYNC_END));
        lcd_vs     = !(running && (v_cnt < V_SYNC_END));
        lcd_de     = running && v_act && h_act;
        pixel_xpos = data_req ? (h_cnt - H_REQ_START) : '0;
        pixel_ypos = data_req ? (v_cnt - V_START) : '0;
        lcd_rgb    = lcd_de ? pixel_data : '0;
    end

    assign lcd_bl = running;
    assign h_disp = 11'(H_DISP);
    assign v_disp = 11'(V_DISP);

endmodule

// File: tb/tb_lcd_timing_driver.sv
// tb_lcd_timing_driver
//
// Drives two copies of lcd_timing_driver from one clock, reset and enable:
// the default 480x272 geometry, and a tiny geometry whose whole frame fits
// in a few hundred clocks so frame wrap and frame_tick repeat often.
// Each copy feeds a pixel mux that registers {13'b0, pixel_xpos}, so the
// low bits of lcd_rgb during DE are the column index.
// Expected outputs come from the elapsed number of enabled cycles:
// position = elapsed mod frame, split into line and column. Sync widths,
// periods and DE placement are also measured and held against
// hand-computed constants.
module tb_lcd_timing_driver;

    typedef struct packed {
        longint h_sync, h_back, h_disp, h_front;
        longint v_sync, v_back, v_disp, v_front;
        longint lit_hs_low, lit_period, lit_de_w, lit_de_off;
        longint lit_last_col, lit_vs_low, lit_first_tick, lit_frame;
    } geom_t;

    typedef struct packed {
        logic        hs, vs, de, bl, tick;
        logic [10:0] x, y;
        logic [23:0] rgb;
    } exp_t;

    logic        lcd_pclk;
    logic        rst_n;
    logic        lcd_en;
    logic [23:0] pix   [2];
    logic [10:0] xpos  [2];
    logic [10:0] ypos  [2];
    logic [10:0] hd    [2];
    logic [10:0] vd    [2];
    logic        hs    [2];
    logic        vs    [2];
    logic        de    [2];
    logic [23:0] rgb   [2];
    logic        bl    [2];
    logic        tick  [2];

    int n_checks = 0;
    int n_fail   = 0;

    logic   mrun;
    longint mt;
    longint cyc;

    longint hs_run [2];
    longint vs_run [2];
    longint de_run [2];
    longint last_hs_fall [2];
    longint last_tick [2];
    longint de_seen [2];
    longint de_checks [2];
    longint tick_checks [2];
    logic        p_hs [2];
    logic        p_vs [2];
    logic        p_de [2];
    logic [23:0] p_rgb [2];

    lcd_timing_driver u_big (
        .lcd_pclk   (lcd_pclk),
        .rst_n      (rst_n),
        .lcd_en     (lcd_en),
        .pixel_data (pix[0]),
        .pixel_xpos (xpos[0]),
        .pixel_ypos (ypos[0]),
        .h_disp     (hd[0]),
        .v_disp     (vd[0]),
        .lcd_hs     (hs[0]),
        .lcd_vs     (vs[0]),
        .lcd_de     (de[0]),
        .lcd_rgb    (rgb[0]),
        .lcd_bl     (bl[0]),
        .frame_tick (tick[0])
    );

    lcd_timing_driver #(
        .H_SYNC(3), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(1), .V_DISP(4), .V_FRONT(2)
    ) u_small (
        .lcd_pclk   (lcd_pclk),
        .rst_n      (rst_n),
        .lcd_en     (lcd_en),
        .pixel_data (pix[1]),
        .pixel_xpos (xpos[1]),
        .pixel_ypos (ypos[1]),
        .h_disp     (hd[1]),
        .v_disp     (vd[1]),
        .lcd_hs     (hs[1]),
        .lcd_vs     (vs[1]),
        .lcd_de     (de[1]),
        .lcd_rgb    (rgb[1]),
        .lcd_bl     (bl[1]),
        .frame_tick (tick[1])
    );

    initial lcd_pclk = 1'b0;
    always #5 lcd_pclk = ~lcd_pclk;

    // Pixel colour mux stand-in: colour is the requested column, one clock late.
    always @(posedge lcd_pclk) begin
        pix[0] <= {13'b0, xpos[0]};
        pix[1] <= {13'b0, xpos[1]};
    end

    // Elapsed enabled cycles: the first cycle after lcd_en is seen is t=0.
    always @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            mrun <= 1'b0;
            mt   <= '0;
        end else begin
            mrun <= lcd_en;
            mt   <= (lcd_en && mrun) ? mt + 1 : '0;
        end
    end

    function automatic geom_t get_geom(input int k);
        geom_t g;
        if (k == 0)
            g = '{41, 2, 480, 2, 10, 2, 272, 2, 41, 525, 480, 43, 479, 5250, 149100, 150150};
        else
            g = '{3, 2, 8, 2, 2, 1, 4, 2, 3, 15, 8, 5, 7, 30, 105, 135};
        return g;
    endfunction

    function automatic exp_t model_out(input geom_t g, input logic run, input longint t);
        exp_t   e;
        longint htot, vtot, frame, p, h, v, hst, vst;
        logic   vact;
        e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0; e.bl = run; e.tick = 1'b0;
        e.x = '0; e.y = '0; e.rgb = '0;
        if (run) begin
            htot  = g.h_sync + g.h_back + g.h_disp + g.h_front;
            vtot  = g.v_sync + g.v_back + g.v_disp + g.v_front;
            frame = htot * vtot;
            p     = t % frame;
            h     = p % htot;
            v     = p / htot;
            hst   = g.h_sync + g.h_back;
            vst   = g.v_sync + g.v_back;
            e.hs  = (h >= g.h_sync);
            e.vs  = (v >= g.v_sync);
            vact  = (v >= vst) && (v < vst + g.v_disp);
            e.de  = vact && (h >= hst) && (h < hst + g.h_disp);
            if (vact && (h + 1 >= hst) && (h + 1 < hst + g.h_disp)) begin
                e.x = 11'(h + 1 - hst);
                e.y = 11'(v - vst);
            end
            if (e.de) e.rgb = 24'(h - hst);
            e.tick = (t >= 1) && (((t - 1) % frame) == (vst + g.v_disp) * htot - 1);
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input int k, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("[TB] FAIL %s[%0d] actual=%0d required=%0d at %0t", name, k, act, req, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input int cycles);
        @(posedge lcd_pclk);
        #1;
        rst_n  = r;
        lcd_en = e;
        repeat (cycles) @(posedge lcd_pclk);
    endtask

    // Per-cycle comparison against the model plus waveform measurements.
    initial begin
        geom_t g;
        exp_t  e;
        cyc = 0;
        for (int k = 0; k < 2; k++) begin
            hs_run[k] = 0; vs_run[k] = 0; de_run[k] = 0;
            last_hs_fall[k] = -1; last_tick[k] = -1;
            de_seen[k] = 0; de_checks[k] = 0; tick_checks[k] = 0;
            p_hs[k] = 1'b1; p_vs[k] = 1'b1; p_de[k] = 1'b0; p_rgb[k] = '0;
        end
        forever begin
            @(negedge lcd_pclk);
            cyc++;
            for (int k = 0; k < 2; k++) begin
                g = get_geom(k);
                e = model_out(g, mrun, mt);
                checkOutput("lcd_hs", k, longint'(hs[k]), longint'(e.hs));
                checkOutput("lcd_vs", k, longint'(vs[k]), longint'(e.vs));
                checkOutput("lcd_de", k, longint'(de[k]), longint'(e.de));
                checkOutput("lcd_bl", k, longint'(bl[k]), longint'(e.bl));
                checkOutput("frame_tick", k, longint'(tick[k]), longint'(e.tick));
                checkOutput("pixel_xpos", k, longint'(xpos[k]), longint'(e.x));
                checkOutput("pixel_ypos", k, longint'(ypos[k]), longint'(e.y));
                checkOutput("lcd_rgb", k, longint'(rgb[k]), longint'(e.rgb));
                checkOutput("h_disp", k, longint'(hd[k]), g.h_disp);
                checkOutput("v_disp", k, longint'(vd[k]), g.v_disp);

                if (!mrun) begin
                    last_hs_fall[k] = -1;
                    last_tick[k]    = -1;
                    de_seen[k]      = 0;
                end

                if (hs[k] == 1'b0) begin
                    if (p_hs[k] == 1'b1 && mrun) begin
                        if (last_hs_fall[k] >= 0)
                            checkOutput("hs_period", k, cyc - last_hs_fall[k], g.lit_period);
                        last_hs_fall[k] = cyc;
                    end
                    hs_run[k]++;
                end else begin
                    if (p_hs[k] == 1'b0 && mrun)
                        checkOutput("hs_low_width", k, hs_run[k], g.lit_hs_low);
                    hs_run[k] = 0;
                end

                if (vs[k] == 1'b0) begin
                    vs_run[k]++;
                end else begin
                    if (p_vs[k] == 1'b0 && mrun)
                        checkOutput("vs_low_cycles", k, vs_run[k], g.lit_vs_low);
                    vs_run[k] = 0;
                end

                if (de[k] == 1'b1) begin
                    if (p_de[k] == 1'b0 && mrun) begin
                        if (last_hs_fall[k] >= 0)
                            checkOutput("de_offset", k, cyc - last_hs_fall[k], g.lit_de_off);
                        checkOutput("first_col", k, longint'(rgb[k][10:0]), 0);
                        if (de_seen[k] == 0)
                            checkOutput("first_row_ypos", k, longint'(ypos[k]), 0);
                        de_seen[k]++;
                    end
                    de_run[k]++;
                end else begin
                    if (p_de[k] == 1'b1 && mrun) begin
                        checkOutput("de_width", k, de_run[k], g.lit_de_w);
                        checkOutput("last_col", k, longint'(p_rgb[k][10:0]), g.lit_last_col);
                        de_checks[k]++;
                    end
                    de_run[k] = 0;
                end

                if (tick[k] == 1'b1) begin
                    if (last_tick[k] >= 0)
                        checkOutput("tick_period", k, cyc - last_tick[k], g.lit_frame);
                    else
                        checkOutput("first_tick_time", k, mt, g.lit_first_tick);
                    tick_checks[k]++;
                    last_tick[k] = cyc;
                end

                p_hs[k]  = hs[k];
                p_vs[k]  = vs[k];
                p_de[k]  = de[k];
                p_rgb[k] = rgb[k];
            end
        end
    end

    // Stimulus: reset, run, async reset mid-line, run to (200,100) on the
    // large raster, drop enable, idle, re-enable, stop.
    initial begin
        logic found;
        rst_n  = 1'b1;
        lcd_en = 1'b0;
        #1 rst_n = 1'b0;
        repeat (4) @(posedge lcd_pclk);

        applyStimulus(1'b1, 1'b1, 7000);

        @(posedge lcd_pclk);
        #3 rst_n = 1'b0;
        repeat (3) @(posedge lcd_pclk);
        applyStimulus(1'b1, 1'b1, 0);

        found = 1'b0;
        for (int i = 0; i < 60000 && !found; i++) begin
            @(posedge lcd_pclk);
            #1;
            if (mrun && mt == 52700) found = 1'b1;
        end
        checkOutput("abort_point_reached", 0, longint'(found), 1);
        lcd_en = 1'b0;
        repeat (300) @(posedge lcd_pclk);

        applyStimulus(1'b1, 1'b1, 7000);
        applyStimulus(1'b1, 1'b0, 20);

        checkOutput("de_lines_measured", 0, longint'(de_checks[0] > 0), 1);
        checkOutput("de_lines_measured", 1, longint'(de_checks[1] > 0), 1);
        checkOutput("ticks_measured", 1, longint'(tick_checks[1] > 2), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
